// File: rtl/rotary_quad_counter.sv
// Quadrature rotary encoder front end: synchronise, debounce and decode A/B, group
// transitions into detent steps and apply them to a bounded saturating/wrapping position.
module rotary_quad_counter #(
    parameter int unsigned     WIDTH         = 32,
    parameter int unsigned     FILTER_CYCLES = 1000,
    parameter int unsigned     FILTER_W      = 16,
    parameter int unsigned     DETENT_STEPS  = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE  = '0
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             A,
    input  logic             B,
    input  logic [WIDTH-1:0] bound_lower,
    input  logic [WIDTH-1:0] bound_upper,
    input  logic             wrap,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] data,
    output logic             step_up,
    output logic             step_down,
    output logic             quad_err
);

    localparam int unsigned ACC_W = 4;
    localparam logic [FILTER_W-1:0]   FILT_LAST = FILTER_W'(FILTER_CYCLES - 1);
    localparam logic signed [ACC_W-1:0] ACC_POS = ACC_W'(DETENT_STEPS);
    localparam logic signed [ACC_W-1:0] ACC_NEG = -ACC_POS;

    // Index 0..3 of {A,B} along the up sequence 11->10->00->01.
    function automatic logic [1:0] gray_idx(input logic [1:0] ab);
        case (ab)
            2'b11:   return 2'd0;
            2'b10:   return 2'd1;
            2'b00:   return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    logic [1:0]          s1_q, s2_q;
    logic [1:0]          filt_q, filt_d;
    logic [FILTER_W-1:0] cnt_q [2];
    logic [FILTER_W-1:0] cnt_d [2];
    logic [1:0]          prev_q, prev_d;
    logic signed [ACC_W-1:0] acc_q, acc_d, acc_step;
    logic                req_up_q, req_up_d, req_dn_q, req_dn_d, err_q, err_d;
    logic [WIDTH-1:0]    data_q, data_d;
    logic                up_q, up_d, dn_q, dn_d;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            s1_q <= 2'b11;
            s2_q <= 2'b11;
        end else begin
            s1_q <= {A, B};
            s2_q <= s1_q;
        end
    end

    // Per-input debounce: a level must disagree for FILTER_CYCLES consecutive cycles.
    always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != filt_q[i]) begin
                if (cnt_q[i] == FILT_LAST) begin
                    filt_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + FILTER_W'(1);
                end
            end
        end
    end

    always_comb begin
        prev_d   = filt_q;
        acc_d    = acc_q;
        acc_step = acc_q;
        req_up_d = 1'b0;
        req_dn_d = 1'b0;
        err_d    = 1'b0;
        if ((filt_q ^ prev_q) == 2'b11) begin
            err_d = 1'b1;
        end else if (filt_q != prev_q) begin
            if (gray_idx(filt_q) == gray_idx(prev_q) + 2'd1) begin
                acc_step = acc_q + ACC_W'(1);
            end else begin
                acc_step = acc_q - ACC_W'(1);
            end
            if (acc_step == ACC_POS) begin
                req_up_d = 1'b1;
                acc_d    = '0;
            end else if (acc_step == ACC_NEG) begin
                req_dn_d = 1'b1;
                acc_d    = '0;
            end else if (DETENT_STEPS == 4 && filt_q == 2'b11) begin
                // Back at the mechanical detent without a full cycle: resynchronise.
                acc_d = '0;
            end else begin
                acc_d = acc_step;
            end
        end
    end

    always_comb begin
        data_d = data_q;
        up_d   = 1'b0;
        dn_d   = 1'b0;
        if (load) begin
            data_d = load_value;
        end else if ((req_up_q || req_dn_q) && (bound_lower <= bound_upper)) begin
            up_d = req_up_q;
            dn_d = req_dn_q;
            if (data_q < bound_lower) begin
                data_d = bound_lower;
            end else if (data_q > bound_upper) begin
                data_d = bound_upper;
            end else if (req_up_q) begin
                if (data_q < bound_upper) begin
                    data_d = data_q + WIDTH'(1);
                end else if (wrap) begin
                    data_d = bound_lower;
                end
            end else begin
                if (data_q > bound_lower) begin
                    data_d = data_q - WIDTH'(1);
                end else if (wrap) begin
                    data_d = bound_upper;
                end
            end
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            filt_q   <= 2'b11;
            cnt_q[0] <= '0;
            cnt_q[1] <= '0;
            prev_q   <= 2'b11;
            acc_q    <= '0;
            req_up_q <= 1'b0;
            req_dn_q <= 1'b0;
            err_q    <= 1'b0;
            data_q   <= RESET_VALUE;
            up_q     <= 1'b0;
            dn_q     <= 1'b0;
        end else begin
            filt_q   <= filt_d;
            cnt_q[0] <= cnt_d[0];
            cnt_q[1] <= cnt_d[1];
            prev_q   <= prev_d;
            acc_q    <= acc_d;
            req_up_q <= req_up_d;
            req_dn_q <= req_dn_d;
            err_q    <= err_d;
            data_q   <= data_d;
            up_q     <= up_d;
            dn_q     <= dn_d;
        end
    end

    assign data      = data_q;
    assign step_up   = up_q;
    assign step_down = dn_q;
    assign quad_err  = err_q;

endmodule

// File: tb/tb_rotary_quad_counter.sv
// Directed bench for rotary_quad_counter: a 4-transition detent build and a 1-transition build
// share all inputs; pulses are tallied by a negedge monitor.
module tb_rotary_quad_counter;

    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         a_r = 1'b1;
    logic         b_r = 1'b1;
    logic         wrap_r = 1'b0;
    logic         load_r = 1'b0;
    logic [W-1:0] lo_r = 16'd0;
    logic [W-1:0] hi_r = 16'd10;
    logic [W-1:0] lv_r = 16'd0;

    logic [W-1:0] data4, data1;
    logic         up4, dn4, err4, up1, dn1, err1;

    int errors = 0;
    int checks = 0;
    int up_cnt = 0;
    int dn_cnt = 0;
    int err_cnt = 0;
    int up_base, dn_base, err_base;

    rotary_quad_counter #(
        .WIDTH(W), .FILTER_CYCLES(4), .FILTER_W(4), .DETENT_STEPS(4), .RESET_VALUE(16'd0)
    ) dut (
        .sys_clk(clk), .sys_rst(rst), .A(a_r), .B(b_r),
        .bound_lower(lo_r), .bound_upper(hi_r), .wrap(wrap_r),
        .load(load_r), .load_value(lv_r),
        .data(data4), .step_up(up4), .step_down(dn4), .quad_err(err4)
    );

    rotary_quad_counter #(
        .WIDTH(W), .FILTER_CYCLES(4), .FILTER_W(4), .DETENT_STEPS(1), .RESET_VALUE(16'd0)
    ) dut1 (
        .sys_clk(clk), .sys_rst(rst), .A(a_r), .B(b_r),
        .bound_lower(lo_r), .bound_upper(hi_r), .wrap(wrap_r),
        .load(load_r), .load_value(lv_r),
        .data(data1), .step_up(up1), .step_down(dn1), .quad_err(err1)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (up4)  up_cnt = up_cnt + 1;
        if (dn4)  dn_cnt = dn_cnt + 1;
        if (err4) err_cnt = err_cnt + 1;
    end

    task automatic set_ab(input logic a, input logic b, input int n);
        @(negedge clk);
        a_r = a;
        b_r = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic detent_up(input int n);
        set_ab(1'b1, 1'b0, n);
        set_ab(1'b0, 1'b0, n);
        set_ab(1'b0, 1'b1, n);
        set_ab(1'b1, 1'b1, n);
        repeat (10) @(negedge clk);
    endtask

    task automatic detent_dn(input int n);
        set_ab(1'b0, 1'b1, n);
        set_ab(1'b0, 1'b0, n);
        set_ab(1'b1, 1'b0, n);
        set_ab(1'b1, 1'b1, n);
        repeat (10) @(negedge clk);
    endtask

    task automatic do_load(input logic [W-1:0] v);
        @(negedge clk);
        load_r = 1'b1;
        lv_r   = v;
        @(negedge clk);
        load_r = 1'b0;
    endtask

    task automatic snap();
        up_base  = up_cnt;
        dn_base  = dn_cnt;
        err_base = err_cnt;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (data4 !== 16'd0) begin
            errors++; $display("FAIL reset_data got %0d want 0", data4);
        end
        checks++;
        if ({up4, dn4, err4} !== 3'b000) begin
            errors++; $display("FAIL reset_pulses got %b want 000", {up4, dn4, err4});
        end
        do_load(16'd7);
        checks++;
        if (data4 !== 16'd7) begin
            errors++; $display("FAIL reset_preload got %0d want 7", data4);
        end
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checks++;
        if (data4 !== 16'd0) begin
            errors++; $display("FAIL async_reset_data got %0d want 0", data4);
        end
        checks++;
        if ({up4, dn4, err4} !== 3'b000) begin
            errors++; $display("FAIL async_reset_pulses got %b want 000", {up4, dn4, err4});
        end
        @(negedge clk);
        rst = 1'b0;
        snap();
        repeat (30) @(negedge clk);
        checks++;
        if (data4 !== 16'd0) begin
            errors++; $display("FAIL idle_hold_data got %0d want 0", data4);
        end
        checks++;
        if ((up_cnt - up_base) != 0 || (dn_cnt - dn_base) != 0 || (err_cnt - err_base) != 0) begin
            errors++; $display("FAIL idle_hold_pulses got up=%0d dn=%0d err=%0d want 0/0/0",
                               up_cnt - up_base, dn_cnt - dn_base, err_cnt - err_base);
        end
    endtask

    task automatic test_up_detent();
        lo_r = 16'd0; hi_r = 16'd10; wrap_r = 1'b0;
        do_load(16'd5);
        snap();
        detent_up(20);
        checks++;
        if (data4 !== 16'd6) begin
            errors++; $display("FAIL up_detent_data got %0d want 6", data4);
        end
        checks++;
        if ((up_cnt - up_base) != 1 || (dn_cnt - dn_base) != 0) begin
            errors++; $display("FAIL up_detent_pulses got up=%0d dn=%0d want 1/0",
                               up_cnt - up_base, dn_cnt - dn_base);
        end
        snap();
        detent_dn(20);
        checks++;
        if (data4 !== 16'd5) begin
            errors++; $display("FAIL down_detent_data got %0d want 5", data4);
        end
        checks++;
        if ((up_cnt - up_base) != 0 || (dn_cnt - dn_base) != 1) begin
            errors++; $display("FAIL down_detent_pulses got up=%0d dn=%0d want 0/1",
                               up_cnt - up_base, dn_cnt - dn_base);
        end
    endtask

    task automatic test_bounce();
        do_load(16'd5);
        snap();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            a_r = 1'b0;
            repeat (3) @(negedge clk);
            a_r = 1'b1;
            repeat (2) @(negedge clk);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (data4 !== 16'd5) begin
            errors++; $display("FAIL bounce_data got %0d want 5", data4);
        end
        checks++;
        if ((up_cnt - up_base) != 0 || (dn_cnt - dn_base) != 0 || (err_cnt - err_base) != 0) begin
            errors++; $display("FAIL bounce_pulses got up=%0d dn=%0d err=%0d want 0/0/0",
                               up_cnt - up_base, dn_cnt - dn_base, err_cnt - err_base);
        end
        detent_up(5);
        checks++;
        if (data4 !== 16'd6) begin
            errors++; $display("FAIL stable5_data got %0d want 6", data4);
        end
        checks++;
        if ((up_cnt - up_base) != 1) begin
            errors++; $display("FAIL stable5_pulses got up=%0d want 1", up_cnt - up_base);
        end
    endtask

    task automatic test_limits();
        lo_r = 16'd0; hi_r = 16'd10; wrap_r = 1'b0;
        do_load(16'd10);
        snap();
        detent_up(20);
        checks++;
        if (data4 !== 16'd10) begin
            errors++; $display("FAIL sat_upper_data got %0d want 10", data4);
        end
        checks++;
        if ((up_cnt - up_base) != 1) begin
            errors++; $display("FAIL sat_upper_pulse got %0d want 1", up_cnt - up_base);
        end
        wrap_r = 1'b1;
        snap();
        detent_up(20);
        checks++;
        if (data4 !== 16'd0) begin
            errors++; $display("FAIL wrap_upper_data got %0d want 0", data4);
        end
        checks++;
        if ((up_cnt - up_base) != 1) begin
            errors++; $display("FAIL wrap_upper_pulse got %0d want 1", up_cnt - up_base);
        end
        wrap_r = 1'b0;
        snap();
        detent_dn(20);
        checks++;
        if (data4 !== 16'd0) begin
            errors++; $display("FAIL sat_lower_data got %0d want 0", data4);
        end
        checks++;
        if ((dn_cnt - dn_base) != 1) begin
            errors++; $display("FAIL sat_lower_pulse got %0d want 1", dn_cnt - dn_base);
        end
        wrap_r = 1'b1;
        snap();
        detent_dn(20);
        checks++;
        if (data4 !== 16'd10) begin
            errors++; $display("FAIL wrap_lower_data got %0d want 10", data4);
        end
        checks++;
        if ((dn_cnt - dn_base) != 1) begin
            errors++; $display("FAIL wrap_lower_pulse got %0d want 1", dn_cnt - dn_base);
        end
        wrap_r = 1'b0;
    endtask

    task automatic test_errors();
        lo_r = 16'd0; hi_r = 16'd10; wrap_r = 1'b0;
        do_load(16'd5);
        snap();
        set_ab(1'b0, 1'b0, 20);
        set_ab(1'b1, 1'b1, 20);
        checks++;
        if ((err_cnt - err_base) != 2) begin
            errors++; $display("FAIL quad_err_count got %0d want 2", err_cnt - err_base);
        end
        set_ab(1'b1, 1'b0, 20);
        set_ab(1'b1, 1'b1, 20);
        checks++;
        if (data4 !== 16'd5) begin
            errors++; $display("FAIL partial_data got %0d want 5", data4);
        end
        checks++;
        if ((up_cnt - up_base) != 0 || (dn_cnt - dn_base) != 0) begin
            errors++; $display("FAIL partial_pulses got up=%0d dn=%0d want 0/0",
                               up_cnt - up_base, dn_cnt - dn_base);
        end
        detent_up(20);
        checks++;
        if (data4 !== 16'd6) begin
            errors++; $display("FAIL after_partial_data got %0d want 6", data4);
        end
        do_load(16'd2);
        detent_up(20);
        checks++;
        if (data1 !== 16'd6) begin
            errors++; $display("FAIL detent1_data got %0d want 6", data1);
        end
        checks++;
        if (data4 !== 16'd3) begin
            errors++; $display("FAIL detent4_ref_data got %0d want 3", data4);
        end
    endtask

    task automatic test_load_bounds();
        lo_r = 16'd0; hi_r = 16'd10; wrap_r = 1'b0;
        do_load(16'd5);
        snap();
        set_ab(1'b1, 1'b0, 20);
        set_ab(1'b0, 1'b0, 20);
        set_ab(1'b0, 1'b1, 20);
        @(negedge clk);
        load_r = 1'b1;
        lv_r   = 16'd42;
        a_r    = 1'b1;
        b_r    = 1'b1;
        repeat (20) @(negedge clk);
        load_r = 1'b0;
        @(negedge clk);
        checks++;
        if (data4 !== 16'd42) begin
            errors++; $display("FAIL load_step_data got %0d want 42", data4);
        end
        checks++;
        if ((up_cnt - up_base) != 0) begin
            errors++; $display("FAIL load_step_pulse got %0d want 0", up_cnt - up_base);
        end
        snap();
        detent_up(20);
        checks++;
        if (data4 !== 16'd10) begin
            errors++; $display("FAIL clamp_data got %0d want 10", data4);
        end
        checks++;
        if ((up_cnt - up_base) != 1) begin
            errors++; $display("FAIL clamp_pulse got %0d want 1", up_cnt - up_base);
        end
        lo_r = 16'd8; hi_r = 16'd3;
        snap();
        detent_up(20);
        detent_dn(20);
        checks++;
        if (data4 !== 16'd10) begin
            errors++; $display("FAIL bad_bounds_data got %0d want 10", data4);
        end
        checks++;
        if ((up_cnt - up_base) != 0 || (dn_cnt - dn_base) != 0) begin
            errors++; $display("FAIL bad_bounds_pulses got up=%0d dn=%0d want 0/0",
                               up_cnt - up_base, dn_cnt - dn_base);
        end
    endtask

    initial begin
        test_reset();
        test_up_detent();
        test_bounce();
        test_limits();
        test_errors();
        test_load_bounds();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
